regfile_swap_arbiter: RTL
=========================

REGFILE_SWAP_ARBITER -- requirements
Module: regfile_swap_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 7, register file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, register file data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
- host_req  in  1  single-cycle host access request.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDRESS_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  DATA_WIDTH  read data, valid while host_gnt=1 and host_we=0.
- swap_req  in  1  swap request.
- swap_addr_a  in  ADDRESS_WIDTH  swap operand A.
- swap_addr_b  in  ADDRESS_WIDTH  swap operand B.
- swap_gnt  out  1  swap accepted this cycle; operands sampled.
- swap_done  out  1  one-cycle pulse on final swap cycle.
- busy  out  1  swap sequence in progress (state != IDLE).
- rf_address_r  out  ADDRESS_WIDTH  register file read address.
- rf_data_r  in  DATA_WIDTH  register file combinational read data.
- rf_address_w  out  ADDRESS_WIDTH  register file write address.
- rf_data_w  out  DATA_WIDTH  register file write data.
- rf_we  out  1  register file write enable.

Function
REQ-005 SHALL implement FSM states IDLE, SWAP_CP, SWAP_WB; internal regs: latched addr A/B, temp (DATA_WIDTH), last_winner.
REQ-006 In IDLE with no request: rf_we=0, rf_address_r=0, rf_address_w=0, rf_data_w=0, all grants 0.
REQ-007 Host grant (IDLE): host_gnt=1 combinationally; rf_address_r=host_addr; host_rdata=rf_data_r; if host_we, rf_we=1, rf_address_w=host_addr, rf_data_w=host_wdata; state stays IDLE.
REQ-008 Swap grant (IDLE): swap_gnt=1; rf_address_r=swap_addr_a; rf_we=0; on clock edge latch swap_addr_a/b, temp<=rf_data_r, go to SWAP_CP.
REQ-009 SWAP_CP: rf_address_r=B; rf_we=1, rf_address_w=A, rf_data_w=rf_data_r; next SWAP_WB.
REQ-010 SWAP_WB: rf_we=1, rf_address_w=B, rf_data_w=temp; swap_done=1; next IDLE.
REQ-011 Swap latency: grant cycle + 2; swap_done exactly 2 cycles after swap_gnt; new request grantable the cycle after swap_done.
REQ-012 host_gnt=0 and swap_gnt=0 in SWAP_CP and SWAP_WB; requesters hold req until granted.
REQ-013 Arbitration in IDLE: one requester -> grant it; both -> grant the one not equal to last_winner; last_winner updates on every grant.
REQ-014 swap_addr_a == swap_addr_b SHALL run the full 3-cycle sequence; contents unchanged.
REQ-015 host_rdata SHALL be 0 whenever host_gnt=0.

Reset
REQ-016 Reset SHALL force state=IDLE, temp=0, latched addresses=0, last_winner=swap (host wins first tie) asynchronously.
REQ-017 While reset asserted: rf_we=0, host_gnt=0, swap_gnt=0, swap_done=0, busy=0.
REQ-018 Reset during SWAP_CP/SWAP_WB SHALL abort with no further writes; swap_done not issued; partial result (A overwritten) is permitted.

Configuration
REQ-019 With REGFILE_ARB_RR_EN defined, tie-break SHALL follow REQ-013 (round-robin).
REQ-020 Without REGFILE_ARB_RR_EN, ties SHALL always grant host (fixed priority); last_winner unused.

Verification
REQ-021 Preload r3=0x11, r9=0x22; swap a=3,b=9 -> swap_gnt cycle 0, swap_done cycle 2; afterwards r3=0x22, r9=0x11.
REQ-022 Host write addr 5 data 0xA5 then host read addr 5 -> host_gnt both cycles, host_rdata=0xA5 in read cycle.
REQ-023 host_req and swap_req held high from reset release (RR_EN defined) -> grant order host, swap(3 cycles), host, swap; no host_gnt while busy=1.
REQ-024 Same as REQ-023 without RR_EN -> host granted every IDLE cycle; swap never granted while host_req=1.
REQ-025 Swap a=b=4 with r4=0x5C -> swap_done at cycle 2, r4=0x5C.
REQ-026 Assert reset in SWAP_WB cycle -> rf_we=0 immediately, busy=0, no swap_done, state IDLE after release.

Source files
------------

// File: rtl/regfile_swap_arbiter.sv
// regfile_swap_arbiter
// Arbitrates single-cycle host accesses and three-cycle swap sequences onto
// one external register file (one combinational read port, one write port).
//
// Optional feature macro: REGFILE_ARB_RR_EN
//   defined   : a simultaneous host/swap request is resolved round-robin,
//               using last_winner (host wins the first tie after reset).
//   undefined : a simultaneous request always grants the host (fixed priority).
//
// Swap sequence:
//   grant cycle (IDLE) : read A, capture it into temp, latch A/B.
//   SWAP_CP            : read B, write it to A.
//   SWAP_WB            : write temp to B, pulse swap_done.
// Reset is asynchronous and active-high.  While it is high, every grant,
// write enable and status output is forced low, so a swap interrupted in
// SWAP_CP or SWAP_WB is dropped without any further write.

module regfile_swap_arbiter #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]    host_wdata,
  output logic                     host_gnt,
  output logic [DATA_WIDTH-1:0]    host_rdata,

  input  logic                     swap_req,
  input  logic [ADDRESS_WIDTH-1:0] swap_addr_a,
  input  logic [ADDRESS_WIDTH-1:0] swap_addr_b,
  output logic                     swap_gnt,
  output logic                     swap_done,
  output logic                     busy,

  output logic [ADDRESS_WIDTH-1:0] rf_address_r,
  input  logic [DATA_WIDTH-1:0]    rf_data_r,
  output logic [ADDRESS_WIDTH-1:0] rf_address_w,
  output logic [DATA_WIDTH-1:0]    rf_data_w,
  output logic                     rf_we
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWAP_CP = 2'd1,
    SWAP_WB = 2'd2
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_a;
  logic [ADDRESS_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0]    temp;

  logic                     grant_host;
  logic                     grant_swap;

`ifdef REGFILE_ARB_RR_EN
  // 1 = swap requester won the most recent grant, 0 = host.
  logic                     last_winner;
`endif

  // Arbitration: only in IDLE and never while reset is asserted.
  always_comb begin
    grant_host = 1'b0;
    grant_swap = 1'b0;
    if (!reset && state == IDLE) begin
      if (host_req && swap_req) begin
`ifdef REGFILE_ARB_RR_EN
        grant_host = last_winner;
        grant_swap = ~last_winner;
`else
        grant_host = 1'b1;
`endif
      end else begin
        grant_host = host_req;
        grant_swap = swap_req;
      end
    end
  end

  // Register file port steering and status outputs for the current state.
  always_comb begin
    host_gnt     = 1'b0;
    host_rdata   = '0;
    swap_gnt     = 1'b0;
    swap_done    = 1'b0;
    rf_address_r = '0;
    rf_address_w = '0;
    rf_data_w    = '0;
    rf_we        = 1'b0;

    case (state)
      IDLE: begin
        if (grant_host) begin
          host_gnt     = 1'b1;
          rf_address_r = host_addr;
          host_rdata   = rf_data_r;
          if (host_we) begin
            rf_we        = 1'b1;
            rf_address_w = host_addr;
            rf_data_w    = host_wdata;
          end
        end else if (grant_swap) begin
          swap_gnt     = 1'b1;
          rf_address_r = swap_addr_a;
        end
      end
      SWAP_CP: begin
        rf_address_r = addr_b;
        rf_we        = 1'b1;
        rf_address_w = addr_a;
        rf_data_w    = rf_data_r;
      end
      SWAP_WB: begin
        rf_we        = 1'b1;
        rf_address_w = addr_b;
        rf_data_w    = temp;
        swap_done    = 1'b1;
      end
      default: ;
    endcase

    // Reset silences the register file port even mid-sequence.
    if (reset) begin
      rf_we     = 1'b0;
      swap_done = 1'b0;
    end
  end

  // busy reflects the registered state, so it drops as soon as reset hits.
  assign busy = (state != IDLE);

  // Sequence state, operand latches, captured data and tie-break history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_a <= '0;
      addr_b <= '0;
      temp   <= '0;
`ifdef REGFILE_ARB_RR_EN
      last_winner <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_swap) begin
            addr_a <= swap_addr_a;
            addr_b <= swap_addr_b;
            temp   <= rf_data_r;
            state  <= SWAP_CP;
          end
`ifdef REGFILE_ARB_RR_EN
          if (grant_host) begin
            last_winner <= 1'b0;
          end else if (grant_swap) begin
            last_winner <= 1'b1;
          end
`endif
        end
        SWAP_CP: state <= SWAP_WB;
        SWAP_WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
